// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell plus a WIDTH-bit bit-serial adder.
// Operand bits arrive LSB-first; the sum is shifted in from the top so it
// is aligned in `result` after WIDTH valid bits.
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  input  logic             start,
  input  logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          ser_s;
  logic          ser_c;

  // Primitive adder cell; independent of state and reset
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

  // Same cell evaluated against the registered serial carry
  always_comb begin
    ser_s = a ^ b ^ carry;
    ser_c = (a & b) | (a & carry) | (b & carry);
  end

  // Serial adder control and datapath; start restarts from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state  <= RUN;
        carry  <= cin;
        cnt    <= '0;
        result <= '0;
      end else if (state == RUN && valid) begin
        result <= {ser_s, result[WIDTH-1:1]};
        carry  <= ser_c;
        cnt    <= cnt + CW'(1);
        if (cnt == LAST) begin
          carry_out <= ser_c;
          done      <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed test of the full adder cell and serial adder.
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       cin;
  logic       sum;
  logic       cout;
  logic       start;
  logic       valid;
  logic [7:0] result;
  logic       carry_out;
  logic       done;

  int tests_run;
  int tests_failed;
  int done_cnt;

  full_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .start     (start),
    .valid     (valid),
    .result    (result),
    .carry_out (carry_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses; each pulse is high for one full cycle
  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truth table indexed by {a,b,cin}
  task automatic check_cell(input string tag);
    logic [7:0] sum_tbl;
    logic [7:0] cout_tbl;
    logic [2:0] idx;
    sum_tbl  = 8'b1001_0110;
    cout_tbl = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {a, b, cin} = idx;
      #1;
      check($sformatf("%s_sum_%0d", tag, i), {31'd0, sum}, {31'd0, sum_tbl[idx]});
      check($sformatf("%s_cout_%0d", tag, i), {31'd0, cout}, {31'd0, cout_tbl[idx]});
    end
  endtask

  // Start an addition and feed 8 bits; optional idle gap before each bit
  task automatic run_add(input string tag, input logic [7:0] opa, input logic [7:0] opb,
                         input logic c0, input bit gaps,
                         input logic [7:0] exp_r, input logic exp_c);
    int base;
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; cin = c0; valid = 1'b1; a = 1'b1; b = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        valid = 1'b0; a = ~opa[i]; b = ~opb[i];
        @(negedge clk);
      end
      a = opa[i]; b = opb[i]; valid = 1'b1;
      @(posedge clk); #1;
      if (i < 7) check({tag, "_early_done"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    valid = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_result"}, {24'd0, result}, {24'd0, exp_r});
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    @(posedge clk); #1;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_result_hold"}, {24'd0, result}, {24'd0, exp_r});
    check({tag, "_pulses"}, done_cnt - base, 32'd1);
  endtask

  initial begin
    int base;
    logic [7:0] pa;
    logic [7:0] pb;
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;

    #2;
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_cell("cell_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_cell("cell");

    run_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_add("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);
    run_add("add_gaps", 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0);

    // Reset in the middle of an operation
    base = done_cnt;
    pa = 8'h5A; pb = 8'h3C;
    @(negedge clk);
    start = 1'b1; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = pa[i]; b = pb[i]; valid = 1'b1;
      @(negedge clk);
    end
    check("mid_partial", {24'd0, result}, 32'h60);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", {24'd0, result}, 32'd0);
    check("mid_rst_carry", {31'd0, carry_out}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    valid = 1'b0;
    check("mid_no_done", done_cnt - base, 32'd0);
    check("mid_idle_result", {24'd0, result}, 32'd0);
    run_add("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Restart after 3 bits of an unrelated operation
    base = done_cnt;
    pa = 8'hFF; pb = 8'hFF;
    @(negedge clk);
    start = 1'b1; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = pa[i]; b = pb[i]; valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    run_add("restart", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
    check("restart_total_pulses", done_cnt - base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
